// File: rtl/sub_seq_pkg.sv
// Shared types and sizing helpers for the chunked sequential subtractor.
package sub_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  localparam int unsigned CHUNK_W = 8;

  function automatic int unsigned calc_nchunk(input int unsigned width);
    return width / CHUNK_W;
  endfunction

  // Counter needs at least one bit even when a single pass suffices.
  function automatic int unsigned calc_cnt_w(input int unsigned nchunk);
    return (nchunk <= 1) ? 1 : $clog2(nchunk);
  endfunction

endpackage

// File: rtl/sub_seq_ctrl_fs8.sv
// fs8: 8-bit ripple subtractor slice, d = a - b - bin with borrow-out.
module fs8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       bin,
  output logic [7:0] d,
  output logic       bout
);

  logic br;

  always_comb begin
    br = bin;
    d  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      d[i] = a[i] ^ b[i] ^ br;
      br   = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & br);
    end
    bout = br;
  end

endmodule

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: WIDTH-bit a - b - bin computed one byte per cycle on a shared fs8.
// Optional signed-overflow flag enabled by defining SUB_OVF_EN.
module sub_seq_ctrl
  import sub_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] d,
  output logic             bout,
  output logic             busy
`ifdef SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned NCHUNK = calc_nchunk(WIDTH);
  localparam int unsigned CNT_W  = calc_cnt_w(NCHUNK);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(NCHUNK - 1);

  state_t                 state;
  logic [WIDTH-1:0]       op_a;
  logic [WIDTH-1:0]       op_b;
  logic                   borrow;
  logic [CNT_W-1:0]       cnt;

  logic [CHUNK_W-1:0]     slice_d;
  logic                   slice_bout;
  logic [WIDTH+CHUNK_W-1:0] d_cat;

`ifdef SUB_OVF_EN
  logic                   a_s;
  logic                   b_s;
`endif

  fs8 u_slice (
    .a    (op_a[CHUNK_W-1:0]),
    .b    (op_b[CHUNK_W-1:0]),
    .bin  (borrow),
    .d    (slice_d),
    .bout (slice_bout)
  );

  assign in_ready = (state == IDLE) & ~rst;

  // New chunk enters at the top; concatenation keeps this legal for WIDTH=8.
  assign d_cat = {slice_d, d};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      op_a      <= '0;
      op_b      <= '0;
      borrow    <= 1'b0;
      cnt       <= '0;
      d         <= '0;
      bout      <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SUB_OVF_EN
      a_s       <= 1'b0;
      b_s       <= 1'b0;
      ovf       <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_a   <= a;
            op_b   <= b;
            borrow <= bin;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= RUN;
`ifdef SUB_OVF_EN
            a_s    <= a[WIDTH-1];
            b_s    <= b[WIDTH-1];
`endif
          end
        end
        RUN: begin
          d      <= d_cat[WIDTH+CHUNK_W-1:CHUNK_W];
          borrow <= slice_bout;
          op_a   <= op_a >> CHUNK_W;
          op_b   <= op_b >> CHUNK_W;
          cnt    <= cnt + 1'b1;
          if (cnt == LAST) begin
            bout      <= slice_bout;
            out_valid <= 1'b1;
            state     <= DONE;
`ifdef SUB_OVF_EN
            // Final slice's top bit is the result sign.
            ovf       <= (a_s != b_s) & (slice_d[CHUNK_W-1] != a_s);
`endif
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
`ifdef SUB_OVF_EN
            ovf       <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
